// File: rtl/cic_decim.sv
// cic_decim: runtime-rate CIC decimation filter with valid/ready streaming on input and output.
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   input_tdata    signed input sample, accepted on input_tvalid & input_tready
//   output_tdata   signed full-precision decimated sample, offered with output_tvalid
//   output_tready  downstream accept; stalls only the decimating input sample
//   rate           decimation factor R (0 behaves as 1, values above RMAX clamp to RMAX)
module cic_decim #(
   parameter int WIDTH = 16,
   parameter int RMAX = 2,
   parameter int M = 1,
   parameter int N = 2,
   parameter int REG_WIDTH = WIDTH + $clog2((RMAX*M)**N)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [WIDTH-1:0]             input_tdata,
   input  logic                         input_tvalid,
   output logic                         input_tready,
   output logic [REG_WIDTH-1:0]         output_tdata,
   output logic                         output_tvalid,
   input  logic                         output_tready,
   input  logic [$clog2(RMAX+1)-1:0]    rate
);
   localparam int CW = RMAX > 1 ? $clog2(RMAX) : 1;
   logic [REG_WIDTH-1:0] r_int [N];
   logic [REG_WIDTH-1:0] r_comb [N];
   logic [REG_WIDTH-1:0] r_dly [N][M];
   logic [CW-1:0] r_cycle;
   logic [REG_WIDTH-1:0] w_x [N];
   logic [REG_WIDTH-1:0] w_ext;
   logic w_in_xfer, w_out_xfer, w_wrap;
   assign w_ext = {{(REG_WIDTH-WIDTH){input_tdata[WIDTH-1]}}, input_tdata};
   assign input_tready = output_tready | (r_cycle != '0);
   assign output_tvalid = input_tvalid & (r_cycle == '0);
   assign output_tdata = r_comb[N-1];
   assign w_in_xfer = input_tvalid & input_tready;
   assign w_out_xfer = output_tvalid & output_tready;
   // phase only advances while below both the hardware limit and the requested rate
   assign w_wrap = !(int'(r_cycle) < RMAX - 1 && int'(r_cycle) + 1 < int'(rate));
   // comb chain: first stage reads the last integrator, later stages the previous comb
   always_comb begin
      w_x[0] = r_int[N-1];
      for (int k = 1; k < N; k++) w_x[k] = r_comb[k-1];
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cycle <= '0;
         for (int k = 0; k < N; k++) begin
            r_int[k] <= '0;
            r_comb[k] <= '0;
            for (int j = 0; j < M; j++) r_dly[k][j] <= '0;
         end
      end else begin
         // integrators and combs wrap freely; the comb differences cancel the wrap
         if (w_in_xfer) begin
            r_cycle <= w_wrap ? '0 : r_cycle + CW'(1);
            r_int[0] <= r_int[0] + w_ext;
            for (int k = 1; k < N; k++) r_int[k] <= r_int[k] + r_int[k-1];
         end
         if (w_out_xfer) begin
            for (int k = 0; k < N; k++) begin
               r_comb[k] <= w_x[k] - r_dly[k][M-1];
               r_dly[k][0] <= w_x[k];
               for (int j = 1; j < M; j++) r_dly[k][j] <= r_dly[k][j-1];
            end
         end
      end
   end
endmodule

// File: tb/tb_cic_decim.sv
// tb_cic_decim: scoreboard bench for cic_decim with a closed-form CIC reference model.
module tb_cic_decim;
   localparam int WIDTH = 16;
   localparam int RMAX = 4;
   localparam int M = 1;
   localparam int N = 2;
   localparam int RW = WIDTH + $clog2((RMAX*M)**N);
   logic clk = 0;
   logic rst = 1;
   logic [WIDTH-1:0] input_tdata = '0;
   logic input_tvalid = 0;
   logic input_tready;
   logic signed [RW-1:0] output_tdata;
   logic output_tvalid;
   logic output_tready = 1;
   logic [2:0] rate = 3'd4;
   cic_decim #(.WIDTH(WIDTH), .RMAX(RMAX), .M(M), .N(N)) dut (
      .clk(clk), .rst(rst),
      .input_tdata(input_tdata), .input_tvalid(input_tvalid), .input_tready(input_tready),
      .output_tdata(output_tdata), .output_tvalid(output_tvalid), .output_tready(output_tready),
      .rate(rate)
   );
   always #5 clk = ~clk;
   int n_cmp = 0;
   int n_bad = 0;
   longint xs[$];
   longint d[$];
   longint sb[$];
   int p = 0;
   logic exp_ready = 1;
   logic exp_ovalid = 0;
   longint last_out = 0;
   logic imp_on = 0;
   longint imp_sum = 0;
   int imp_nz = 0;
   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask
   function automatic longint wrap(input longint v);
      logic signed [RW-1:0] r;
      r = v[RW-1:0];
      return longint'(r);
   endfunction
   function automatic longint binom(input longint n, input int k);
      longint r = 1;
      if (n < k || n < 0) return 0;
      for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
      return r;
   endfunction
   // last-integrator value just before input i: sum of x[j] * C(i-1-j, N-1)
   function automatic longint pre_int(input int i);
      longint s = 0;
      for (int j = 0; j < i; j++) s += xs[j] * binom(i - 1 - j, N - 1);
      return s;
   endfunction
   function automatic longint dget(input int idx);
      return idx < 0 ? 0 : d[idx];
   endfunction
   // output presented at decimated transfer t: N-th order M-difference of d, delayed N outputs
   function automatic longint yval(input int t);
      longint s = 0;
      for (int k = 0; k <= N; k++)
         s += ((k % 2) ? -1 : 1) * binom(N, k) * dget(t - N - k * M);
      return wrap(s);
   endfunction
   task automatic step(input logic v, input logic [WIDTH-1:0] dat, input logic ordy, input logic [2:0] rt);
      int reff;
      @(posedge clk);
      #1;
      input_tvalid = v;
      input_tdata = dat;
      output_tready = ordy;
      rate = rt;
      exp_ready = ordy | (p != 0);
      exp_ovalid = v & (p == 0);
      if (v && exp_ready) begin
         if (p == 0) begin
            d.push_back(pre_int(xs.size()));
            sb.push_back(yval(d.size() - 1));
         end
         xs.push_back(longint'($signed(dat)));
         reff = rt == 0 ? 1 : (int'(rt) > RMAX ? RMAX : int'(rt));
         p = (p + 1 < reff) ? p + 1 : 0;
      end
   endtask
   // reset asserted between edges; state must clear without waiting for a clock
   task automatic do_reset();
      step(0, '0, 1, rate);
      #2;
      rst = 1;
      input_tvalid = 1;
      #1;
      chk("async_rst_data", output_tdata, 0);
      chk("async_rst_tready", input_tready, 1);
      chk("async_rst_tvalid", output_tvalid, 1);
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      input_tvalid = 0;
      xs.delete();
      d.delete();
      sb.delete();
      p = 0;
      exp_ready = output_tready;
      exp_ovalid = 0;
   endtask
   task automatic dc_run(input logic [WIDTH-1:0] x, input logic [2:0] rt, input int cycles, input longint settle, input string nm);
      do_reset();
      for (int i = 0; i < cycles; i++) step(1, x, 1, rt);
      @(negedge clk);
      chk(nm, last_out, settle);
   endtask
   always @(negedge clk) begin
      if (!rst) begin
         chk("input_tready", input_tready, exp_ready);
         chk("output_tvalid", output_tvalid, exp_ovalid);
         if (output_tvalid && output_tready) begin
            if (sb.size() == 0) begin
               chk("unexpected_output", 1, 0);
            end else begin
               chk("output_tdata", output_tdata, sb.pop_front());
               last_out = output_tdata;
               if (imp_on) begin
                  imp_sum += output_tdata;
                  if (output_tdata != 0) imp_nz++;
               end
            end
         end
      end
   end
   initial begin
      repeat (3) @(posedge clk);
      chk("reset_data", output_tdata, 0);
      chk("reset_tready", input_tready, 1);
      chk("reset_tvalid", output_tvalid, 0);
      #1;
      rst = 0;
      dc_run(16'd1, 3'd4, 40, 16, "dc_plus1_r4");
      dc_run(16'hFFFF, 3'd4, 40, -16, "dc_minus1_r4");
      dc_run(16'd1, 3'd2, 30, 4, "dc_r2");
      dc_run(16'd1, 3'd1, 20, 1, "dc_r1");
      dc_run(16'd1, 3'd0, 20, 1, "dc_r0");
      dc_run(16'd1, 3'd7, 40, 16, "dc_r7_clamp");
      dc_run(16'h8000, 3'd4, 40, -524288, "full_scale");
      // impulse at decimation phase 0: decimated taps of (1+z^-1+z^-2+z^-3)^2 sum to 16/R
      do_reset();
      imp_on = 1;
      imp_sum = 0;
      imp_nz = 0;
      step(1, 16'd100, 1, 3'd4);
      for (int i = 0; i < 40; i++) step(1, '0, 1, 3'd4);
      @(negedge clk);
      imp_on = 0;
      chk("impulse_sum", imp_sum, 400);
      chk("impulse_len_ok", imp_nz <= N + 1, 1);
      chk("impulse_nonzero", imp_nz > 0, 1);
      // backpressure: stall at phase 0, registers must hold the pending comb result
      do_reset();
      for (int i = 0; i < 10; i++) step(1, WIDTH'($urandom), 1, 3'd4);
      for (int i = 0; i < 20; i++) begin
         step(1, WIDTH'($urandom), 0, 3'd4);
         if (i == 10 || i == 19) begin
            chk("stall_phase0", p, 0);
            chk("stall_data", output_tdata, yval(d.size()));
         end
      end
      for (int i = 0; i < 40; i++) step(1, WIDTH'($urandom), 1, 3'd4);
      // randomized valid/ready/data with occasional rate changes and a mid-stream reset
      begin
         logic [2:0] rt = 3'd4;
         for (int seg = 0; seg < 2; seg++) begin
            do_reset();
            for (int i = 0; i < 1500; i++) begin
               if (i % 60 == 0) rt = 3'($urandom_range(0, 7));
               step($urandom_range(0, 9) < 8, WIDTH'($urandom), $urandom_range(0, 9) < 7, rt);
            end
         end
      end
      step(0, '0, 1, 3'd4);
      @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
